rca_multibyte_seq: RTL and testbench

Sequencer stage that sits directly upstream of the 8-bit ripple-carry adder. It feeds that adder one byte pair per cycle and captures its sum and carry, so the single 8-bit adder performs an NBYTES-wide addition. The carry ripples through a register between bytes. Operands enter and results leave over valid/ready handshakes.

---
 rtl/rca_multibyte_seq_pkg.sv | 21 ++
 rtl/rca_multibyte_seq.sv | 113 +++++++++++
 tb/tb_rca_multibyte_seq.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rca_multibyte_seq_pkg.sv
// Shared types and helpers for the multi-byte ripple-carry sequencer.
// Operands are walked one byte at a time through an external 8-bit adder.
package rca_multibyte_seq_pkg;

  localparam int BYTE_W     = 8;
  // Upper bound on NBYTES; the byte extractor works on a vector of this width.
  localparam int MAX_NBYTES = 32;
  localparam int MAX_W      = BYTE_W * MAX_NBYTES;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_e;

  function automatic logic [BYTE_W-1:0] get_byte(input logic [MAX_W-1:0] vec,
                                                 input int unsigned      idx);
    return vec[BYTE_W*idx +: BYTE_W];
  endfunction

endpackage

// File: rtl/rca_multibyte_seq.sv
// Sequencer that drives a single 8-bit adder across NBYTES byte lanes, rippling
// the carry through a register, with valid/ready handshakes on both sides.
module rca_multibyte_seq
  import rca_multibyte_seq_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [BYTE_W*NBYTES-1:0] in_a_i,
  input  logic [BYTE_W*NBYTES-1:0] in_b_i,
  input  logic                     in_cin_i,
  output logic [BYTE_W-1:0]        add_a_o,
  output logic [BYTE_W-1:0]        add_b_o,
  output logic                     add_cin_o,
  input  logic [BYTE_W-1:0]        add_sum_i,
  input  logic                     add_cout_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [BYTE_W*NBYTES-1:0] out_sum_o,
  output logic                     out_cout_o,
  output logic                     busy_o
);

  localparam int              W        = BYTE_W * NBYTES;
  localparam int              IW       = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0]   LAST_IDX = IW'(NBYTES - 1);

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q,   idx_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_q,     a_d;
  logic [W-1:0]    b_q,     b_d;
  logic [W-1:0]    sum_q,   sum_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours; data registers are reset too because
  // the result bus must read zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    add_a_o   = '0;
    add_b_o   = '0;
    add_cin_o = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          a_d     = in_a_i;
          b_d     = in_b_i;
          carry_d = in_cin_i;
          idx_d   = '0;
          state_d = ADD;
        end
      end

      ADD: begin
        // The adder is combinational: its result for this lane is captured
        // on the same edge that retires the lane.
        add_a_o   = get_byte(MAX_W'(a_q), 32'(idx_q));
        add_b_o   = get_byte(MAX_W'(b_q), 32'(idx_q));
        add_cin_o = carry_q;
        sum_d[BYTE_W*int'(idx_q) +: BYTE_W] = add_sum_i;
        carry_d   = add_cout_i;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IW'(1);
        end
      end

      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign busy_o      = (state_q != IDLE);
  assign out_sum_o   = sum_q;
  assign out_cout_o  = carry_q;

endmodule

// File: tb/tb_rca_multibyte_seq.sv
// Scoreboard bench for rca_multibyte_seq: NBYTES=4 and NBYTES=1 instances, each
// paired with a behavioural 8-bit adder, checked against plain-arithmetic sums.
module tb_rca_multibyte_seq;

  localparam int NB  = 4;
  localparam int W   = 8 * NB;
  localparam int W1  = W + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic         in_valid = 1'b0, in_ready;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic         in_cin = 1'b0;
  logic [7:0]   add_a, add_b, add_sum;
  logic         add_cin, add_cout;
  logic         out_valid, out_ready = 1'b1;
  logic [W-1:0] out_sum;
  logic         out_cout, busy;

  logic         s_in_valid = 1'b0, s_in_ready;
  logic [7:0]   s_in_a = '0, s_in_b = '0;
  logic         s_in_cin = 1'b0;
  logic [7:0]   s_add_a, s_add_b, s_add_sum;
  logic         s_add_cin, s_add_cout;
  logic         s_out_valid, s_out_ready = 1'b1;
  logic [7:0]   s_out_sum;
  logic         s_out_cout, s_busy;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int last_accept = 0;

  logic [W:0] exp_q[$];
  logic [8:0] exp1_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural 8-bit adders standing in for the ripple-carry stage.
  assign {add_cout, add_sum}     = 9'(add_a) + 9'(add_b) + 9'(add_cin);
  assign {s_add_cout, s_add_sum} = 9'(s_add_a) + 9'(s_add_b) + 9'(s_add_cin);

  rca_multibyte_seq #(.NBYTES(NB)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_a_i(in_a), .in_b_i(in_b), .in_cin_i(in_cin),
    .add_a_o(add_a), .add_b_o(add_b), .add_cin_o(add_cin),
    .add_sum_i(add_sum), .add_cout_i(add_cout),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_sum_o(out_sum), .out_cout_o(out_cout), .busy_o(busy)
  );

  rca_multibyte_seq #(.NBYTES(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(s_in_valid), .in_ready_o(s_in_ready),
    .in_a_i(s_in_a), .in_b_i(s_in_b), .in_cin_i(s_in_cin),
    .add_a_o(s_add_a), .add_b_o(s_add_b), .add_cin_o(s_add_cin),
    .add_sum_i(s_add_sum), .add_cout_i(s_add_cout),
    .out_valid_o(s_out_valid), .out_ready_i(s_out_ready),
    .out_sum_o(s_out_sum), .out_cout_o(s_out_cout), .busy_o(s_busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic cin);
    return {1'b0, a} + {1'b0, b} + W1'(cin);
  endfunction

  // Carry entering byte i is the overflow of the sum of the lower i bytes.
  function automatic bit carry_into(input longint unsigned a, input longint unsigned b,
                                    input int cin, input int i);
    longint unsigned m, s;
    m = (64'd1 << (8 * i)) - 64'd1;
    s = (a & m) + (b & m) + longint'(cin);
    return s[8 * i];
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: got 0x%0h expected none", {out_cout, out_sum});
      end else begin
        check("result", 64'({out_cout, out_sum}), 64'(exp_q.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && s_out_valid && s_out_ready) begin
      if (exp1_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result_n1: got 0x%0h expected none", {s_out_cout, s_out_sum});
      end else begin
        check("result_n1", 64'({s_out_cout, s_out_sum}), 64'(exp1_q.pop_front()));
      end
    end
  end

  // Waits for in_ready, then completes the accept on the following edge.
  task automatic accept_wait(input bit keep, input bit rand_rdy);
    int n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 100) begin
        check("accept_timeout", 64'(n), 64'(0));
        return;
      end
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end
    @(posedge clk);
    exp_q.push_back(model(in_a, in_b, in_cin));
    #1;
    last_accept = cyc;
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                      input bit keep, input bit rand_rdy);
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_valid = 1'b1;
    accept_wait(keep, rand_rdy);
  endtask

  task automatic wait_valid(output int lat);
    int n = 0;
    lat = -1;
    forever begin
      @(negedge clk);
      if (out_valid) break;
      n++;
      if (n > 50) begin
        check("valid_timeout", 64'(n), 64'(0));
        return;
      end
    end
    lat = cyc - last_accept;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0 && exp1_q.size() == 0 && in_ready && s_in_ready) break;
      n++;
      if (n > 200) begin
        check("drain_timeout", 64'(exp_q.size()), 64'(0));
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_n1(input logic [7:0] a, input logic [7:0] b, input logic cin);
    int t, n;
    s_in_a = a;
    s_in_b = b;
    s_in_cin = cin;
    s_in_valid = 1'b1;
    @(negedge clk);
    check("n1_in_ready", 64'(s_in_ready), 64'(1));
    @(posedge clk);
    exp1_q.push_back(9'(a) + 9'(b) + 9'(cin));
    #1;
    t = cyc;
    s_in_valid = 1'b0;
    n = 0;
    forever begin
      @(negedge clk);
      if (s_out_valid) break;
      n++;
      if (n > 20) break;
    end
    check("n1_latency", 64'(cyc - t), 64'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, h, t1;
    logic [W-1:0] a, b;
    logic         c;

    #1;
    check("reset_ready_valid_busy", 64'({in_ready, out_valid, busy}), 64'(3'b100));
    check("reset_adder_if", 64'({add_a, add_b, add_cin}), 64'(0));
    check("reset_result", 64'({out_cout, out_sum}), 64'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Byte 0 carry propagates into byte 1; latency is NBYTES edges.
    send(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    wait_valid(lat);
    check("latency", 64'(lat), 64'(NB));
    check("busy_in_done", 64'({busy, in_ready}), 64'(2'b10));
    drain();

    // All-ones plus carry-in: carry ripples through every lane.
    send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < NB; i++) begin
      @(negedge clk);
      check($sformatf("add_cin_byte%0d", i), 64'(add_cin),
            64'(carry_into(64'(in_a), 64'(in_b), 1, i)));
      check($sformatf("add_a_byte%0d", i), 64'(add_a), 64'((64'(in_a) >> (8 * i)) & 64'hFF));
    end
    drain();

    // Backpressure: result held stable, concurrent input not accepted.
    out_ready = 1'b0;
    send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b0);
    wait_valid(lat);
    @(posedge clk);
    #1;
    in_a = 32'hA5A5_A5A5;
    in_b = 32'h0F0F_0F0F;
    in_cin = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid_ready", 64'({out_valid, in_ready}), 64'(2'b10));
      check("hold_sum", 64'({out_cout, out_sum}), 64'(model(32'h1234_5678, 32'h1111_1111, 1'b0)));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    h = cyc;
    accept_wait(1'b0, 1'b0);
    check("accept_after_handshake", 64'(last_accept - h), 64'(2));
    drain();

    // Reset mid-operation discards the in-flight result.
    send(32'hDEAD_BEEF, 32'h0102_0304, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_state", 64'({in_ready, out_valid, busy}), 64'(3'b100));
    check("midreset_outputs", 64'({out_cout, out_sum, add_a, add_b, add_cin}), 64'(0));
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    send(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
    drain();

    // Back-to-back with in_valid held: accepts NBYTES+2 apart.
    send(32'h7FFF_0001, 32'h0000_FFFF, 1'b0, 1'b1, 1'b0);
    t1 = last_accept;
    in_a = 32'h8000_0000;
    in_b = 32'h8000_0000;
    in_cin = 1'b1;
    accept_wait(1'b0, 1'b0);
    check("b2b_spacing", 64'(last_accept - t1), 64'(NB + 2));
    drain();

    // Randomised operands with random consumer backpressure.
    for (int k = 0; k < 25; k++) begin
      a = $urandom();
      b = $urandom();
      c = 1'($urandom_range(0, 1));
      if (k % 5 == 0) b = ~a;
      send(a, b, c, 1'b0, 1'b1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
    drain();

    // Single-byte instance.
    send_n1(8'h80, 8'h80, 1'b0);
    for (int k = 0; k < 6; k++) begin
      send_n1(8'($urandom()), 8'($urandom()), 1'($urandom_range(0, 1)));
      @(posedge clk);
      #1;
    end
    drain();

    check("scoreboard_empty", 64'(exp_q.size() + exp1_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
